// File: rtl/mbi5153_hub_arbiter_if.sv
// HUB arbiter handshake bundle: requests/completions from the controller and
// executors, launch strobes, grant, mux select and status.
// Statistics signals exist only when MBI5153_HUB_ARB_STATS_EN is defined.
interface mbi5153_hub_arbiter_if;
  logic        enable;
  logic        req_vsync;
  logic        req_rcfg;
  logic        req_upgs;
  logic        done_vsync;
  logic        done_rcfg;
  logic        done_upgs;
  logic        start_vsync;
  logic        start_rcfg;
  logic        start_upgs;
  logic [1:0]  gnt;
  logic        hub_sel_cmd;
  logic        busy;
  logic [2:0]  ovf;
  logic        timeout;
`ifdef MBI5153_HUB_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_vsync_gnt;
  logic [15:0] stat_rcfg_gnt;
  logic [15:0] stat_upgs_gnt;
  logic [7:0]  stat_tmo;

  modport master (
    output enable, req_vsync, req_rcfg, req_upgs, done_vsync, done_rcfg, done_upgs, stat_clr,
    input  start_vsync, start_rcfg, start_upgs, gnt, hub_sel_cmd, busy, ovf, timeout,
    input  stat_vsync_gnt, stat_rcfg_gnt, stat_upgs_gnt, stat_tmo
  );
  modport slave (
    input  enable, req_vsync, req_rcfg, req_upgs, done_vsync, done_rcfg, done_upgs, stat_clr,
    output start_vsync, start_rcfg, start_upgs, gnt, hub_sel_cmd, busy, ovf, timeout,
    output stat_vsync_gnt, stat_rcfg_gnt, stat_upgs_gnt, stat_tmo
  );
`else
  modport master (
    output enable, req_vsync, req_rcfg, req_upgs, done_vsync, done_rcfg, done_upgs,
    input  start_vsync, start_rcfg, start_upgs, gnt, hub_sel_cmd, busy, ovf, timeout
  );
  modport slave (
    input  enable, req_vsync, req_rcfg, req_upgs, done_vsync, done_rcfg, done_upgs,
    output start_vsync, start_rcfg, start_upgs, gnt, hub_sel_cmd, busy, ovf, timeout
  );
`endif
endinterface

// File: rtl/mbi5153_hub_arbiter.sv
// MBI5153 HUB arbiter: latches VSYNC / RCFG / UPGS requests, grants one job at
// a time (VSYNC > RCFG > UPGS), watchdogs it and inserts a guard gap after it.
// Optional grant/timeout statistics: define MBI5153_HUB_ARB_STATS_EN.
module mbi5153_hub_arbiter #(
  parameter int unsigned GUARD_CLKS   = 4,
  parameter int unsigned TIMEOUT_CLKS = 65535,
  parameter int unsigned TMO_WIDTH    = $clog2(TIMEOUT_CLKS + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  mbi5153_hub_arbiter_if.slave bus
);

  localparam int unsigned GuardWidth = (GUARD_CLKS > 1) ? $clog2(GUARD_CLKS) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGuard} state_e;

  state_e                state_q, state_d;
  logic [2:0]            pend_q, pend_d;
  logic [2:0]            ovf_q, ovf_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  sel_q, sel_d;
  logic [TMO_WIDTH-1:0]  wdog_q, wdog_d;
  logic [GuardWidth-1:0] guard_q, guard_d;
  logic [2:0]            req, done, start;
  logic [1:0]            winner;
  logic                  done_gnt, expired, launch, tmo;

  // Bit order everywhere: {UPGS, RCFG, VSYNC}; grant code is bit index + 1.
  assign req  = {bus.req_upgs, bus.req_rcfg, bus.req_vsync};
  assign done = {bus.done_upgs, bus.done_rcfg, bus.done_vsync};

  assign expired = (wdog_q == TMO_WIDTH'(TIMEOUT_CLKS));
  assign launch  = bus.enable && (pend_q != 3'b000);

  // Fixed-priority pick among pending jobs
  always_comb begin
    winner = 2'd3;
    if (pend_q[0]) winner = 2'd1;
    else if (pend_q[1]) winner = 2'd2;
  end

  // Completion of the granted job only; other DONE strobes are ignored
  always_comb begin
    case (gnt_q)
      2'd1:    done_gnt = done[0];
      2'd2:    done_gnt = done[1];
      2'd3:    done_gnt = done[2];
      default: done_gnt = 1'b0;
    endcase
  end

  // A START consumes the pending flag, but a same-cycle request re-arms it
  assign pend_d = (pend_q & ~start) | req;
  assign ovf_d  = req & pend_q & ~start;

  // Next-state, grant, watchdog and guard logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    guard_d = guard_q;
    start   = 3'b000;
    tmo     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StLaunch;
          gnt_d   = winner;
          sel_d   = (winner != 2'd3);
        end
      end
      StLaunch: begin
        start   = {gnt_q == 2'd3, gnt_q == 2'd2, gnt_q == 2'd1};
        state_d = StWait;
        wdog_d  = TMO_WIDTH'(1);
      end
      StWait: begin
        if (done_gnt || expired) begin
          // DONE in the expiry cycle counts as a normal release
          tmo     = !done_gnt;
          gnt_d   = 2'd0;
          guard_d = '0;
          state_d = (GUARD_CLKS == 0) ? StIdle : StGuard;
        end else begin
          wdog_d = wdog_q + TMO_WIDTH'(1);
        end
      end
      StGuard: begin
        if (guard_q == GuardWidth'(GUARD_CLKS - 1)) begin
          // Last guard cycle hands straight to the next launch when work waits
          if (launch) begin
            state_d = StLaunch;
            gnt_d   = winner;
            sel_d   = (winner != 2'd3);
          end else begin
            state_d = StIdle;
          end
        end else begin
          guard_d = guard_q + GuardWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= 3'b000;
      ovf_q   <= 3'b000;
      gnt_q   <= 2'd0;
      sel_q   <= 1'b0;
      wdog_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      guard_q <= guard_d;
    end
  end

  assign bus.start_vsync = start[0];
  assign bus.start_rcfg  = start[1];
  assign bus.start_upgs  = start[2];
  assign bus.gnt         = gnt_q;
  assign bus.hub_sel_cmd = sel_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.ovf         = ovf_q;
  assign bus.timeout     = tmo;

`ifdef MBI5153_HUB_ARB_STATS_EN
  logic [2:0][15:0] stat_gnt_q;
  logic [7:0]       stat_tmo_q;

  // Saturating grant and timeout counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt_q <= '0;
      stat_tmo_q <= '0;
    end else if (bus.stat_clr) begin
      stat_gnt_q <= '0;
      stat_tmo_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (start[i] && (stat_gnt_q[i] != 16'hffff)) stat_gnt_q[i] <= stat_gnt_q[i] + 16'd1;
      end
      if (tmo && (stat_tmo_q != 8'hff)) stat_tmo_q <= stat_tmo_q + 8'd1;
    end
  end

  assign bus.stat_vsync_gnt = stat_gnt_q[0];
  assign bus.stat_rcfg_gnt  = stat_gnt_q[1];
  assign bus.stat_upgs_gnt  = stat_gnt_q[2];
  assign bus.stat_tmo       = stat_tmo_q;
`endif

endmodule

// File: doc/mbi5153_hub_arbiter.md
Name: mbi5153_hub_arbiter

Overview:
- Schedules the three jobs that share the MBI5153 HUB serial interface (DCLK/LATCH/RGB): driver VSYNC command, register (re-)configuration sequence (PREA + WRC1..3), and frame GS update.
- Sits between mbi5153_ctrl and the executors (mbi5153_commands, mbi5153_rcfg, mbi5153_frame).
- Latches requests, grants exactly one job at a time, and inserts a guard gap between jobs.
- Watchdogs each job and drives the HUB output mux select.

Parameters:
- GUARD_CLKS, 4, idle CLK cycles between end of one job and start of the next (0 allowed).
- TIMEOUT_CLKS, 65535, max CLK cycles a granted job may run before forced release.
- TMO_WIDTH, $clog2(TIMEOUT_CLKS+1), watchdog counter width.

Ports:
- CLK  in  1  DCLK domain clock
- RESET_N  in  1  asynchronous active-low reset
- ENABLE  in  1  1 = new grants allowed; 0 = finish current job, then hold in IDLE
- REQ_VSYNC, REQ_RCFG, REQ_UPGS  in  1 each  request strobes (any high cycle = one request)
- DONE_VSYNC, DONE_RCFG, DONE_UPGS  in  1 each  executor completion strobes
- START_VSYNC, START_RCFG, START_UPGS  out  1 each  1-cycle launch strobe to the executor
- GNT  out  2  00 none, 01 VSYNC, 10 RCFG, 11 UPGS
- HUB_SEL_CMD  out  1  1 = command path owns HUB (VSYNC/RCFG), 0 = line path
- BUSY  out  1  high in every state except IDLE
- OVF  out  3  {UPGS,RCFG,VSYNC} 1-cycle strobe: request arrived while already pending
- TIMEOUT  out  1  1-cycle strobe on watchdog expiry

Behaviour:
- Reset (async assert, sync release): state IDLE; pending flags, counters, GNT cleared. All outputs 0 except HUB_SEL_CMD = 0.
- Reset mid-job drops the grant. No START is re-issued after release.
- Pending flags: set by REQ_x in any state. Cleared in the cycle START_x is driven.
  - REQ_x while pend_x is already 1 → OVF[x] pulse next cycle; the request is not queued twice.
  - REQ_x in the same cycle as START_x → pend_x stays 1; no OVF.
- State IDLE: if ENABLE and any pending → go to LAUNCH.
  - Winner is chosen by fixed priority VSYNC > RCFG > UPGS and registered into GNT on entry to LAUNCH.
- State LAUNCH (1 cycle): START_x = 1 for the winner. GNT valid. HUB_SEL_CMD = 1 for VSYNC/RCFG, 0 for UPGS. Next state WAIT.
  - Latency from REQ (IDLE, ENABLE=1) to START = 2 cycles.
- State WAIT: watchdog counts from 1.
  - DONE_x for the granted job → GUARD (or IDLE if GUARD_CLKS = 0). GNT cleared.
  - DONE strobes for non-granted jobs are ignored.
  - Watchdog reaching TIMEOUT_CLKS → TIMEOUT pulse, GNT cleared, go to GUARD.
  - DONE and expiry in the same cycle → DONE wins; no TIMEOUT.
- State GUARD: count GUARD_CLKS cycles with GNT = 00. HUB_SEL_CMD holds its last value. Then IDLE.
- The RCFG job is atomic: a VSYNC request arriving during RCFG waits until RCFG DONE plus guard.
- ENABLE deassert never aborts WAIT or GUARD.
- Counters saturate, never wrap. GNT changes only on LAUNCH entry or WAIT exit.

Optional Feature:
- Macro MBI5153_HUB_ARB_STATS_EN.
- Defined:
  - Adds outputs STAT_VSYNC_GNT, STAT_RCFG_GNT, STAT_UPGS_GNT (16 bits each, saturating grant counters incremented on START).
  - Adds STAT_TMO (8 bits, saturating TIMEOUT counter).
  - Adds input STAT_CLR (sync clear, priority over increment).
  - All counters reset to 0.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- REQ_UPGS pulse at cycle 0 (ENABLE=1, GUARD_CLKS=4) → START_UPGS at cycle 2, GNT=11, HUB_SEL_CMD=0. DONE_UPGS at cycle 10 → GNT=00 at 11, BUSY low at cycle 15.
- REQ_VSYNC, REQ_RCFG, REQ_UPGS in the same cycle → START order VSYNC, RCFG, UPGS. Each START follows the previous DONE by GUARD_CLKS+1 cycles.
- During an RCFG grant, pulse REQ_VSYNC twice → one OVF[0] pulse. VSYNC is started only after DONE_RCFG plus guard, and exactly once.
- TIMEOUT_CLKS=20, granted job never signals DONE → TIMEOUT pulse 20 cycles after START. GNT=00, and the next pending job is launched after the guard.
- DONE_RCFG and watchdog expiry coincide → no TIMEOUT; normal release. A stray DONE_UPGS during an RCFG grant → ignored.
- RESET_N low for 1 cycle mid-WAIT → all outputs 0 immediately. No START after release until a new REQ. With MBI5153_HUB_ARB_STATS_EN defined, grant counters read 0.
